// File: rtl/tower_topk_sorter.sv
// Streaming top-K tower sorter: keeps the K highest-ET towers at/above threshold
// in a sorted register list, presented as rank-ordered flattened buses at frame end.
module tower_topk_sorter #(
  parameter int unsigned ET_W  = 10,
  parameter int unsigned E_W   = 10,
  parameter int unsigned ETA_W = 6,
  parameter int unsigned PHI_W = 6,
  parameter int unsigned K     = 8,
  parameter int unsigned CNT_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ET_W-1:0]      et_threshold,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ET_W-1:0]      in_et,
  input  logic [E_W-1:0]       in_e,
  input  logic [ETA_W-1:0]     in_eta,
  input  logic [PHI_W-1:0]     in_phi,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [K*ET_W-1:0]    out_ets,
  output logic [K*E_W-1:0]     out_es,
  output logic [K*ETA_W-1:0]   out_etas,
  output logic [K*PHI_W-1:0]   out_phis,
  output logic [CNT_W-1:0]     out_count,
  output logic [CNT_W-1:0]     out_nseen,
  output logic [CNT_W-1:0]     out_nkept
);

  typedef enum logic {COLLECT, DONE} state_t;

  state_t            state, state_nx;
  logic [K-1:0]      slot_v;
  logic [ET_W-1:0]   slot_et  [K];
  logic [E_W-1:0]    slot_e   [K];
  logic [ETA_W-1:0]  slot_eta [K];
  logic [PHI_W-1:0]  slot_phi [K];
  logic [CNT_W-1:0]  n_seen, n_kept;
  logic [K-1:0]      ins_here, shift;
  logic              accept, qualified, release_frame;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= COLLECT;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    release_frame = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          release_frame = 1'b1;
          state_nx      = COLLECT;
        end
      end
      default: state_nx = COLLECT;
    endcase
  end

  assign accept    = in_valid && in_ready;
  assign qualified = accept && (in_et >= et_threshold);

  // First beaten slot takes the new tower; every slot after it shifts down one rank.
  always_comb begin
    logic found;
    logic beats;
    found    = 1'b0;
    beats    = 1'b0;
    ins_here = '0;
    shift    = '0;
    for (int unsigned i = 0; i < K; i++) begin
      beats       = !slot_v[i] || (in_et > slot_et[i]);
      ins_here[i] = beats && !found;
      shift[i]    = found;
      found       = found | beats;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_v <= '0;
      for (int unsigned i = 0; i < K; i++) begin
        slot_et[i]  <= '0;
        slot_e[i]   <= '0;
        slot_eta[i] <= '0;
        slot_phi[i] <= '0;
      end
    end else if (release_frame) begin
      slot_v <= '0;
      for (int unsigned i = 0; i < K; i++) begin
        slot_et[i]  <= '0;
        slot_e[i]   <= '0;
        slot_eta[i] <= '0;
        slot_phi[i] <= '0;
      end
    end else if (qualified) begin
      for (int unsigned i = 0; i < K; i++) begin
        if (ins_here[i]) begin
          slot_v[i]   <= 1'b1;
          slot_et[i]  <= in_et;
          slot_e[i]   <= in_e;
          slot_eta[i] <= in_eta;
          slot_phi[i] <= in_phi;
        end
      end
      for (int unsigned i = 1; i < K; i++) begin
        if (shift[i]) begin
          slot_v[i]   <= slot_v[i-1];
          slot_et[i]  <= slot_et[i-1];
          slot_e[i]   <= slot_e[i-1];
          slot_eta[i] <= slot_eta[i-1];
          slot_phi[i] <= slot_phi[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_seen <= '0;
      n_kept <= '0;
    end else if (release_frame) begin
      n_seen <= '0;
      n_kept <= '0;
    end else begin
      if (accept && (n_seen != '1))    n_seen <= n_seen + 1'b1;
      if (qualified && (n_kept != '1)) n_kept <= n_kept + 1'b1;
    end
  end

  always_comb begin
    out_count = '0;
    out_ets   = '0;
    out_es    = '0;
    out_etas  = '0;
    out_phis  = '0;
    for (int unsigned i = 0; i < K; i++) begin
      out_count                   = out_count + CNT_W'(slot_v[i]);
      out_ets[i*ET_W +: ET_W]     = slot_et[i];
      out_es[i*E_W +: E_W]        = slot_e[i];
      out_etas[i*ETA_W +: ETA_W]  = slot_eta[i];
      out_phis[i*PHI_W +: PHI_W]  = slot_phi[i];
    end
  end

  assign out_nseen = n_seen;
  assign out_nkept = n_kept;

endmodule

// File: tb/tb_tower_topk_sorter.sv
// Bench for tower_topk_sorter: table vectors, random frames against a rank-counting
// reference model, DONE hold, mid-frame reset, and counter saturation on a narrow instance.
module tb_tower_topk_sorter;
  localparam int unsigned ET_W = 10, E_W = 10, ETA_W = 6, PHI_W = 6, K = 8;
  localparam int unsigned CNT_W = 10, CNT_WB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [ET_W-1:0] et_threshold = '0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [ET_W-1:0] in_et = '0;
  logic [E_W-1:0] in_e = '0;
  logic [ETA_W-1:0] in_eta = '0;
  logic [PHI_W-1:0] in_phi = '0;

  logic in_ready, out_valid;
  logic [K*ET_W-1:0] out_ets;
  logic [K*E_W-1:0] out_es;
  logic [K*ETA_W-1:0] out_etas;
  logic [K*PHI_W-1:0] out_phis;
  logic [CNT_W-1:0] out_count, out_nseen, out_nkept;

  logic in_ready_b, out_valid_b;
  logic [K*ET_W-1:0] out_ets_b;
  logic [K*E_W-1:0] out_es_b;
  logic [K*ETA_W-1:0] out_etas_b;
  logic [K*PHI_W-1:0] out_phis_b;
  logic [CNT_WB-1:0] out_count_b, out_nseen_b, out_nkept_b;

  tower_topk_sorter #(.ET_W(ET_W), .E_W(E_W), .ETA_W(ETA_W), .PHI_W(PHI_W), .K(K), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .et_threshold(et_threshold), .in_valid(in_valid), .in_ready(in_ready),
    .in_et(in_et), .in_e(in_e), .in_eta(in_eta), .in_phi(in_phi), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_ets(out_ets), .out_es(out_es),
    .out_etas(out_etas), .out_phis(out_phis), .out_count(out_count), .out_nseen(out_nseen),
    .out_nkept(out_nkept));

  tower_topk_sorter #(.ET_W(ET_W), .E_W(E_W), .ETA_W(ETA_W), .PHI_W(PHI_W), .K(K), .CNT_W(CNT_WB)) dut_b (
    .clk(clk), .rst(rst), .et_threshold(et_threshold), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_et(in_et), .in_e(in_e), .in_eta(in_eta), .in_phi(in_phi), .in_last(in_last),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_ets(out_ets_b), .out_es(out_es_b),
    .out_etas(out_etas_b), .out_phis(out_phis_b), .out_count(out_count_b), .out_nseen(out_nseen_b),
    .out_nkept(out_nkept_b));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: accepted towers of the current frame, in arrival order.
  int unsigned m_et[$], m_e[$], m_eta[$], m_phi[$];
  int unsigned m_seen;
  logic [K*ET_W-1:0] x_ets;
  logic [K*E_W-1:0] x_es;
  logic [K*ETA_W-1:0] x_etas;
  logic [K*PHI_W-1:0] x_phis;

  function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_et.delete(); m_e.delete(); m_eta.delete(); m_phi.delete();
    m_seen = 0;
  endtask

  // Rank of a kept tower = towers with higher ET plus earlier towers of equal ET.
  task automatic build_exp();
    int unsigned r;
    x_ets = '0; x_es = '0; x_etas = '0; x_phis = '0;
    for (int j = 0; j < m_et.size(); j++) begin
      r = 0;
      for (int k = 0; k < m_et.size(); k++)
        if (m_et[k] > m_et[j] || (m_et[k] == m_et[j] && k < j)) r++;
      if (r < K) begin
        x_ets[r*ET_W +: ET_W]    = ET_W'(m_et[j]);
        x_es[r*E_W +: E_W]       = E_W'(m_e[j]);
        x_etas[r*ETA_W +: ETA_W] = ETA_W'(m_eta[j]);
        x_phis[r*PHI_W +: PHI_W] = PHI_W'(m_phi[j]);
      end
    end
  endtask

  task automatic send(input int unsigned et, input int unsigned e, input int unsigned eta,
                      input int unsigned phi, input logic last);
    check("in_ready_collect", 128'(in_ready), 128'(1));
    in_et = ET_W'(et); in_e = E_W'(e); in_eta = ETA_W'(eta); in_phi = PHI_W'(phi);
    in_last = last; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    m_seen++;
    if (et >= int'(et_threshold)) begin
      m_et.push_back(et); m_e.push_back(e); m_eta.push_back(eta); m_phi.push_back(phi);
    end
  endtask

  task automatic check_frame(input string tag);
    build_exp();
    check({tag, "_out_valid"}, 128'(out_valid), 128'(1));
    check({tag, "_ets"}, 128'(out_ets), 128'(x_ets));
    check({tag, "_es"}, 128'(out_es), 128'(x_es));
    check({tag, "_etas"}, 128'(out_etas), 128'(x_etas));
    check({tag, "_phis"}, 128'(out_phis), 128'(x_phis));
    check({tag, "_count"}, 128'(out_count), 128'(sat(m_et.size(), K)));
    check({tag, "_nseen"}, 128'(out_nseen), 128'(sat(m_seen, 1023)));
    check({tag, "_nkept"}, 128'(out_nkept), 128'(sat(m_et.size(), 1023)));
    check({tag, "_b_ets"}, 128'(out_ets_b), 128'(x_ets));
    check({tag, "_b_nseen"}, 128'(out_nseen_b), 128'(sat(m_seen, 15)));
    check({tag, "_b_nkept"}, 128'(out_nkept_b), 128'(sat(m_et.size(), 15)));
  endtask

  task automatic release_frame();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("rel_in_ready", 128'(in_ready), 128'(1));
    check("rel_out_valid", 128'(out_valid), 128'(0));
    check("rel_ets_clear", 128'(out_ets), 128'(0));
    check("rel_count_clear", 128'(out_count), 128'(0));
    check("rel_nseen_clear", 128'(out_nseen), 128'(0));
    model_reset();
  endtask

  typedef struct {
    logic [ET_W-1:0] thr;
    int unsigned n;
    int unsigned ets[12];
    int unsigned cnt, nseen, nkept;
    logic [K*ET_W-1:0] x_ets;
    logic [K*ETA_W-1:0] x_etas;
  } vec_t;

  vec_t tbl[3];

  initial begin
    tbl[0].thr = 10'd0; tbl[0].n = 5;
    tbl[0].ets[0] = 5; tbl[0].ets[1] = 30; tbl[0].ets[2] = 12; tbl[0].ets[3] = 30; tbl[0].ets[4] = 1;
    tbl[0].cnt = 5; tbl[0].nseen = 5; tbl[0].nkept = 5;
    tbl[0].x_ets  = {10'd0, 10'd0, 10'd0, 10'd1, 10'd5, 10'd12, 10'd30, 10'd30};
    tbl[0].x_etas = {6'd0, 6'd0, 6'd0, 6'd4, 6'd0, 6'd2, 6'd3, 6'd1};
    tbl[1].thr = 10'd10; tbl[1].n = 12;
    for (int i = 0; i < 12; i++) tbl[1].ets[i] = i + 1;
    tbl[1].cnt = 3; tbl[1].nseen = 12; tbl[1].nkept = 3;
    tbl[1].x_ets  = {10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd10, 10'd11, 10'd12};
    tbl[1].x_etas = {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd9, 6'd10, 6'd11};
    tbl[2].thr = 10'd20; tbl[2].n = 4;
    tbl[2].ets[0] = 3; tbl[2].ets[1] = 19; tbl[2].ets[2] = 0; tbl[2].ets[3] = 7;
    tbl[2].cnt = 0; tbl[2].nseen = 4; tbl[2].nkept = 0;
    tbl[2].x_ets = '0; tbl[2].x_etas = '0;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 128'(in_ready), 128'(1));
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_ets", 128'(out_ets), 128'(0));
    check("reset_nseen", 128'(out_nseen), 128'(0));
    check("reset_count", 128'(out_count), 128'(0));
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 3; t++) begin
      et_threshold = tbl[t].thr;
      for (int unsigned i = 0; i < tbl[t].n; i++)
        send(tbl[t].ets[i], i, i, i, i == tbl[t].n - 1);
      check($sformatf("tbl%0d_out_valid", t), 128'(out_valid), 128'(1));
      check($sformatf("tbl%0d_ets", t), 128'(out_ets), 128'(tbl[t].x_ets));
      check($sformatf("tbl%0d_etas", t), 128'(out_etas), 128'(tbl[t].x_etas));
      check($sformatf("tbl%0d_count", t), 128'(out_count), 128'(tbl[t].cnt));
      check($sformatf("tbl%0d_nseen", t), 128'(out_nseen), 128'(tbl[t].nseen));
      check($sformatf("tbl%0d_nkept", t), 128'(out_nkept), 128'(tbl[t].nkept));
      release_frame();
    end

    for (int f = 0; f < 5; f++) begin
      et_threshold = ET_W'($urandom_range(0, 5));
      for (int i = 0; i < 20; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
        send($urandom_range(0, 15), $urandom_range(0, 1023), i, $urandom_range(0, 63), i == 19);
      end
      check_frame($sformatf("rnd%0d", f));
      if (f == 4) begin
        // Frame is held while upstream keeps offering a tower.
        in_et = 10'd1023; in_last = 1'b1; in_valid = 1'b1;
        repeat (5) begin
          @(posedge clk); #1;
          check("hold_in_ready", 128'(in_ready), 128'(0));
          check("hold_out_valid", 128'(out_valid), 128'(1));
          check("hold_ets", 128'(out_ets), 128'(x_ets));
          check("hold_nseen", 128'(out_nseen), 128'(20));
        end
        in_valid = 1'b0; in_last = 1'b0;
      end
      release_frame();
    end

    et_threshold = '0;
    for (int i = 0; i < 3; i++) send(50 + i, i, i, i, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("midrst_ets", 128'(out_ets), 128'(0));
    check("midrst_nseen", 128'(out_nseen), 128'(0));
    check("midrst_count", 128'(out_count), 128'(0));
    check("midrst_in_ready", 128'(in_ready), 128'(1));
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    send(7, 3, 2, 1, 1'b1);
    check("post_rst_count", 128'(out_count), 128'(1));
    check("post_rst_rank0", 128'(out_ets[ET_W-1:0]), 128'(7));
    check_frame("post_rst");
    release_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
